instr_feeder: RTL and testbench

INSTR_FEEDER -- requirements
Module: instr_feeder

---
 rtl/instr_feeder.sv | 109 ++++++++++
 tb/tb_instr_feeder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_feeder.sv
// Instruction feeder: streams a small loaded program into a processor's IR port,
// holding the processor in reset for a fixed number of cycles before each run.
module instr_feeder #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 16,
    parameter int              RST_HOLD = 2,
    parameter logic [XLEN-1:0] NOP      = 32'h00000013,
    parameter int              AW       = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load_en,
    input  logic [AW-1:0]   load_addr,
    input  logic [XLEN-1:0] load_data,
    input  logic [AW:0]     prog_len,
    input  logic            loop_mode,
    input  logic            start,
    input  logic            abort,
    input  logic            ir_ready,
    output logic            proc_reset,
    output logic [XLEN-1:0] ir,
    output logic            ir_valid,
    output logic [AW-1:0]   idx,
    output logic [15:0]     issued,
    output logic            busy,
    output logic            done
);

    localparam int              HW        = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HW-1:0]   HOLD_INIT = HW'(RST_HOLD - 1);
    localparam logic [AW:0]     LEN_MAX   = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

    state_t          state, state_nx;
    logic [XLEN-1:0] mem [DEPTH];
    logic [HW-1:0]   hold_cnt;
    logic [AW:0]     eff_len;
    logic            loop_q;

    logic        idle_like;
    logic        can_start;
    logic        accept;
    logic        last;
    logic [AW:0] start_len;

    assign idle_like = (state == IDLE) || (state == DONE);
    assign start_len = (prog_len > LEN_MAX) ? LEN_MAX : prog_len;
    assign can_start = idle_like && start && !abort && (start_len != '0);
    assign accept    = (state == RUN) && ir_ready;
    assign last      = ({1'b0, idx} == eff_len - (AW+1)'(1));

    assign proc_reset = (state == IDLE) || (state == HOLD);
    assign ir_valid   = (state == RUN);
    assign ir         = ir_valid ? mem[idx] : NOP;
    assign busy       = (state == HOLD) || (state == RUN);
    assign done       = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Abort beats every other transition out of HOLD/RUN.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (can_start) state_nx = HOLD;
            HOLD: begin
                if (abort)                 state_nx = IDLE;
                else if (hold_cnt == '0)   state_nx = RUN;
            end
            RUN: begin
                if (abort)                         state_nx = IDLE;
                else if (accept && last && !loop_q) state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt <= '0;
            idx      <= '0;
            issued   <= '0;
            eff_len  <= '0;
            loop_q   <= 1'b0;
        end else if (can_start) begin
            hold_cnt <= HOLD_INIT;
            idx      <= '0;
            issued   <= '0;
            eff_len  <= start_len;
            loop_q   <= loop_mode;
        end else if (!abort) begin
            if (state == HOLD && hold_cnt != '0)
                hold_cnt <= hold_cnt - HW'(1);
            if (accept) begin
                idx <= last ? '0 : idx + AW'(1);
                if (issued != 16'hFFFF) issued <= issued + 16'd1;
            end
        end
    end

    // Program memory is deliberately outside the reset domain so a reset replays it.
    always_ff @(posedge clk) begin
        if (load_en && idle_like) mem[load_addr] <= load_data;
    end

endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder: a run-level behavioural model checked every
// cycle, plus literal expectations pinning the key scenarios.
module tb_instr_feeder;
    localparam int          XLEN = 32, DEPTH = 16, RST_HOLD = 2, AW = 4;
    localparam logic [31:0] NOP = 32'h00000013, I0 = 32'h00500093, I1 = 32'h00700113;

    logic            clk = 0, rst_n = 0;
    logic            load_en = 0, loop_mode = 0, start = 0, abort = 0, ir_ready = 0;
    logic [AW-1:0]   load_addr = '0;
    logic [XLEN-1:0] load_data = '0;
    logic [AW:0]     prog_len = '0;
    logic            proc_reset, ir_valid, busy, done;
    logic [XLEN-1:0] ir;
    logic [AW-1:0]   idx;
    logic [15:0]     issued;

    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    instr_feeder #(.XLEN(XLEN), .DEPTH(DEPTH), .RST_HOLD(RST_HOLD), .NOP(NOP), .AW(AW)) dut (
        .clk(clk), .reset(rst_n), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .prog_len(prog_len), .loop_mode(loop_mode),
        .start(start), .abort(abort), .ir_ready(ir_ready), .proc_reset(proc_reset),
        .ir(ir), .ir_valid(ir_valid), .idx(idx), .issued(issued), .busy(busy), .done(done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: phase 0=idle 1=hold 2=run 3=done; pos is the next program entry to issue,
    // hold_left the number of reset cycles still to be shown.
    int          m_phase = 0, m_hold_left = 0, m_pos = 0, m_len = 0, m_issued = 0;
    bit          m_loop = 0;
    logic [31:0] m_mem [DEPTH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0; m_pos = 0; m_issued = 0;
        end else begin
            case (m_phase)
                0, 3: begin
                    if (load_en) m_mem[load_addr] = load_data;
                    if (start && !abort && prog_len != 0) begin
                        m_phase = 1; m_hold_left = RST_HOLD; m_pos = 0; m_issued = 0;
                        m_len = (int'(prog_len) < DEPTH) ? int'(prog_len) : DEPTH;
                        m_loop = loop_mode;
                    end
                end
                1: begin
                    if (abort) m_phase = 0;
                    else begin
                        m_hold_left--;
                        if (m_hold_left == 0) m_phase = 2;
                    end
                end
                default: begin
                    if (abort) m_phase = 0;
                    else if (ir_ready) begin
                        if (m_issued < 65535) m_issued++;
                        m_pos++;
                        if (m_pos == m_len) begin
                            m_pos = 0;
                            if (!m_loop) m_phase = 3;
                        end
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("proc_reset", {31'b0, proc_reset}, {31'b0, m_phase <= 1});
            chk("ir_valid", {31'b0, ir_valid}, {31'b0, m_phase == 2});
            chk("ir", ir, (m_phase == 2) ? m_mem[m_pos] : NOP);
            chk("busy", {31'b0, busy}, {31'b0, m_phase == 1 || m_phase == 2});
            chk("done", {31'b0, done}, {31'b0, m_phase == 3});
            chk("issued", {16'b0, issued}, m_issued);
            if (m_phase == 2) chk("idx", {28'b0, idx}, m_pos);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic go(input int len, input bit lp);
        prog_len = len[AW:0]; loop_mode = lp; start = 1;
        tick();
        start = 0;
    endtask

    initial begin
        int n;
        #12;
        chk("rst_proc_reset", {31'b0, proc_reset}, 1);
        chk("rst_ir", ir, NOP);
        chk("rst_ir_valid", {31'b0, ir_valid}, 0);
        chk("rst_busy_done", {30'b0, busy, done}, 0);
        chk("rst_issued", {16'b0, issued}, 0);
        rst_n = 1;
        tick();

        for (int i = 0; i < DEPTH; i++) begin
            load_en = 1; load_addr = i[AW-1:0];
            load_data = (i == 0) ? I0 : (i == 1) ? I1 : 32'h1000_0000 + i;
            tick();
        end
        load_en = 0;

        // two-entry program, no stalls
        ir_ready = 1;
        go(2, 0);
        chk("r20_hold1", {30'b0, proc_reset, busy}, 2'b11);
        tick();
        chk("r20_hold2", {31'b0, proc_reset}, 1);
        tick();
        chk("r20_ir0", ir, I0);
        chk("r20_prst", {31'b0, proc_reset}, 0);
        tick();
        chk("r20_ir1", ir, I1);
        tick();
        chk("r20_done", {31'b0, done}, 1);
        chk("r20_issued", {16'b0, issued}, 2);
        chk("r20_nop", ir, NOP);

        // stall three cycles on the second entry
        go(2, 0);
        tick(); tick();
        chk("r21_ir0", ir, I0);
        tick();
        ir_ready = 0;
        for (int k = 0; k < 3; k++) begin
            chk("r21_stall_ir", ir, I1);
            chk("r21_stall_issued", {16'b0, issued}, 1);
            tick();
        end
        ir_ready = 1;
        chk("r21_ir_last", ir, I1);
        tick();
        chk("r21_done", {31'b0, done}, 1);
        chk("r21_issued", {16'b0, issued}, 2);

        // looping run, 7 accepts, then abort while stalled
        go(2, 1);
        tick(); tick();
        for (int k = 0; k < 7; k++) begin
            chk("r22_ir", ir, k[0] ? I1 : I0);
            tick();
        end
        chk("r22_issued", {16'b0, issued}, 7);
        chk("r22_busy_done", {30'b0, busy, done}, 2'b10);
        ir_ready = 0; abort = 1;
        tick();
        abort = 0; ir_ready = 1;
        chk("r22_abort_idle", {30'b0, busy, proc_reset}, 2'b01);

        // abort together with an acceptance (and start) at idx 1
        go(2, 0);
        tick(); tick(); tick();
        chk("r23_idx", {28'b0, idx}, 1);
        abort = 1; start = 1;
        tick();
        abort = 0; start = 0;
        chk("r23_issued", {16'b0, issued}, 1);
        chk("r23_prst_vld", {30'b0, proc_reset, ir_valid}, 2'b10);
        chk("r23_busy", {31'b0, busy}, 0);

        // zero length ignored; oversize clamps to DEPTH; changes mid-run ignored
        go(0, 0);
        chk("r24_len0", {30'b0, busy, proc_reset}, 2'b01);
        go(31, 0);
        prog_len = 3; loop_mode = 1;
        tick(); tick();
        load_en = 1; load_addr = 5; load_data = 32'hDEAD_BEEF;
        tick();
        load_en = 0;
        n = 0;
        while (!done && n < 40) begin tick(); n++; end
        chk("r24_finished", {31'b0, done}, 1);
        chk("r24_issued", {16'b0, issued}, 16);

        // asynchronous reset mid-run, then replay
        go(4, 1);
        tick(); tick(); tick(); tick();
        #2 rst_n = 0;
        #1;
        chk("r25_ir", ir, NOP);
        chk("r25_prst", {31'b0, proc_reset}, 1);
        chk("r25_issued", {16'b0, issued}, 0);
        chk("r25_busy", {31'b0, busy}, 0);
        #1 rst_n = 1;
        tick();
        go(2, 0);
        tick(); tick();
        chk("r25_replay0", ir, I0);
        tick();
        chk("r25_replay1", ir, I1);
        tick();
        chk("r25_done", {16'b0, issued}, 2);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
